// File: rtl/div_share_arbiter.sv
// Round-robin arbiter that shares one multi-cycle divider among NUM_REQ requesters.
// It issues start, masks stale finish levels, bounds the wait, and returns the result with a done pulse.
module div_share_arbiter #(
   parameter int NUM_REQ  = 4,
   parameter int DATA_W   = 16,
   parameter int MIN_WAIT = 2,
   parameter int TIMEOUT  = 63
) (
   input  logic                        clk,
   input  logic                        reset_n,
   input  logic [NUM_REQ-1:0]          req,
   input  logic [NUM_REQ*DATA_W-1:0]   req_a,
   input  logic [NUM_REQ*DATA_W-1:0]   req_b,
   output logic [NUM_REQ-1:0]          grant,
   output logic [NUM_REQ-1:0]          done,
   output logic [DATA_W-1:0]           result,
   output logic                        ovf,
   output logic                        timeout_err,
   output logic                        busy,
   output logic [DATA_W-1:0]           div_a,
   output logic [DATA_W-1:0]           div_b,
   output logic                        div_start,
   input  logic [DATA_W-1:0]           div_result,
   input  logic                        div_overflow,
   input  logic                        div_finish
);

   localparam int SEL_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int CNT_W = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

   state_t             state;
   logic [SEL_W-1:0]   rr_ptr;
   logic [SEL_W-1:0]   sel;
   logic [CNT_W-1:0]   cnt;
   logic [SEL_W-1:0]   pick;
   logic               any_req;

   function automatic logic [SEL_W-1:0] wrap_idx(input logic [SEL_W-1:0] base, input int off);
      int s;
      s = int'(base) + off;
      if (s >= NUM_REQ) s = s - NUM_REQ;
      return SEL_W'(s);
   endfunction

   // First requester at or above rr_ptr, wrapping; earlier offsets take priority.
   always_comb begin
      // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
      pick    = rr_ptr;
      any_req = 1'b0;
      for (int k = 0; k < NUM_REQ; k++) begin
         if (!any_req && req[wrap_idx(rr_ptr, k)]) begin
            pick    = wrap_idx(rr_ptr, k);
            any_req = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state       <= IDLE;
         rr_ptr      <= '0;
         sel         <= '0;
         cnt         <= '0;
         grant       <= '0;
         done        <= '0;
         result      <= '0;
         ovf         <= 1'b0;
         timeout_err <= 1'b0;
         busy        <= 1'b0;
         div_a       <= '0;
         div_b       <= '0;
         div_start   <= 1'b0;
      end else begin
         // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
         grant     <= '0;
         done      <= '0;
         div_start <= 1'b0;
         case (state)
            IDLE: begin
               if (any_req) begin
                  grant <= NUM_REQ'(1) << pick;
                  sel   <= pick;
                  div_a <= req_a[pick*DATA_W +: DATA_W];
                  div_b <= req_b[pick*DATA_W +: DATA_W];
                  busy  <= 1'b1;
                  state <= ISSUE;
               end
            end
            ISSUE: begin
               div_start <= 1'b1;
               cnt       <= '0;
               state     <= WAIT;
            end
            WAIT: begin
               // The first MIN_WAIT cycles may still see the previous operation's finish level.
               if (cnt >= CNT_W'(MIN_WAIT) && div_finish) begin
                  result <= div_result;
                  ovf    <= div_overflow;
                  state  <= RESP;
               end else if (cnt == CNT_W'(TIMEOUT)) begin
                  timeout_err <= 1'b1;
                  result      <= '0;
                  ovf         <= 1'b1;
                  state       <= RESP;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            RESP: begin
               done   <= NUM_REQ'(1) << sel;
               rr_ptr <= (sel == SEL_W'(NUM_REQ - 1)) ? '0 : sel + 1'b1;
               busy   <= 1'b0;
               state  <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_div_share_arbiter.sv
// Self-checking bench: Q8.8 divider stub, timeline-based reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_div_share_arbiter;

   localparam int N  = 4;
   localparam int W  = 16;
   localparam int MW = 2;
   localparam int TO = 63;

   logic             clk = 1'b0;
   logic             reset_n = 1'b0;
   logic [N-1:0]     req = '0;
   logic [N*W-1:0]   req_a = '0;
   logic [N*W-1:0]   req_b = '0;
   logic [N-1:0]     grant, done;
   logic [W-1:0]     result, div_a, div_b, div_result;
   logic             ovf, timeout_err, busy, div_start, div_overflow, div_finish;

   div_share_arbiter #(.NUM_REQ(N), .DATA_W(W), .MIN_WAIT(MW), .TIMEOUT(TO)) dut (
      .clk(clk), .reset_n(reset_n), .req(req), .req_a(req_a), .req_b(req_b),
      .grant(grant), .done(done), .result(result), .ovf(ovf), .timeout_err(timeout_err),
      .busy(busy), .div_a(div_a), .div_b(div_b), .div_start(div_start),
      .div_result(div_result), .div_overflow(div_overflow), .div_finish(div_finish)
   );

   always #5 clk = ~clk;

   int n_pass = 0;
   int n_total = 0;
   int cyc;

   always @(posedge clk or negedge reset_n)
      if (!reset_n) cyc <= 0; else cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
   endtask

   // ---------------- divider stub: Q8.8 quotient (A<<8)/B ----------------
   int        st_lat = 24;
   bit        st_never = 1'b0;
   bit        st_stale = 1'b0;
   int        s_cnt;
   bit        s_act;
   logic [W-1:0] s_q;
   logic      s_o;

   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         s_cnt <= 0; s_act <= 1'b0; s_q <= '0; s_o <= 1'b0;
      end else if (div_start) begin
         logic [31:0] q;
         q = (div_b == 0) ? 32'hFFFF_FFFF : ({16'b0, div_a} << 8) / {16'b0, div_b};
         s_q   <= q[15:0];
         s_o   <= (q[31:16] != 0);
         s_cnt <= 1;
         s_act <= 1'b1;
      end else if (s_act && s_cnt < 1000) begin
         s_cnt <= s_cnt + 1;
      end
   end

   assign div_finish   = !st_never && s_act && (s_cnt >= st_lat || (st_stale && s_cnt < 2));
   assign div_result   = s_q;
   assign div_overflow = s_o;

   // ---------------- reference model: timeline of one operation ----------------
   logic [N-1:0] exp_grant, exp_done;
   logic [W-1:0] exp_result, exp_a, exp_b;
   logic         exp_ovf, exp_terr, exp_busy, exp_start;
   int           m_ptr, m_sel, m_age, m_res_age;
   bit           m_active, m_res;

   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         exp_grant = '0; exp_done = '0; exp_result = '0; exp_a = '0; exp_b = '0;
         exp_ovf = 1'b0; exp_terr = 1'b0; exp_busy = 1'b0; exp_start = 1'b0;
         m_ptr = 0; m_sel = 0; m_age = 0; m_res_age = 0; m_active = 0; m_res = 0;
      end else begin
         exp_grant = '0; exp_done = '0; exp_start = 1'b0;
         if (!m_active) begin
            if (req != 0) begin
               for (int k = N - 1; k >= 0; k--)
                  if (req[(m_ptr + k) % N]) m_sel = (m_ptr + k) % N;
               exp_grant = N'(1) << m_sel;
               exp_a     = req_a[m_sel*W +: W];
               exp_b     = req_b[m_sel*W +: W];
               exp_busy  = 1'b1;
               m_active  = 1; m_res = 0; m_age = 0;
            end
         end else begin
            // m_age is the age (cycles since grant) of the cycle that just ended
            if (m_age == 0) begin
               exp_start = 1'b1;
            end else if (!m_res) begin
               if (div_finish && (m_age - 1) >= MW) begin
                  exp_result = div_result; exp_ovf = div_overflow;
                  m_res = 1; m_res_age = m_age;
               end else if ((m_age - 1) == TO) begin
                  exp_result = '0; exp_ovf = 1'b1; exp_terr = 1'b1;
                  m_res = 1; m_res_age = m_age;
               end
            end else if (m_age == m_res_age + 1) begin
               exp_done = N'(1) << m_sel;
               m_ptr    = (m_sel + 1) % N;
               exp_busy = 1'b0;
               m_active = 0;
            end
            m_age++;
         end
      end
   end

   always @(negedge clk) begin
      if (reset_n) begin
         check("grant", 32'(grant), 32'(exp_grant));
         check("done", 32'(done), 32'(exp_done));
         check("result", 32'(result), 32'(exp_result));
         check("ovf", 32'(ovf), 32'(exp_ovf));
         check("timeout_err", 32'(timeout_err), 32'(exp_terr));
         check("busy", 32'(busy), 32'(exp_busy));
         check("div_a", 32'(div_a), 32'(exp_a));
         check("div_b", 32'(div_b), 32'(exp_b));
         check("div_start", 32'(div_start), 32'(exp_start));
      end
   end

   // ---------------- helpers ----------------
   function automatic int oh_idx(input logic [N-1:0] v);
      for (int i = 0; i < N; i++) if (v[i]) return i;
      return -1;
   endfunction

   // kind: 0 = grant, 1 = div_start, 2 = done
   task automatic wait_for(input int kind, input int max, output int at);
      at = -1;
      for (int i = 0; i < max; i++) begin
         @(negedge clk);
         if ((kind == 0 && grant != 0) || (kind == 1 && div_start) || (kind == 2 && done != 0)) begin
            at = cyc;
            return;
         end
      end
      n_total++;
      $display("FAIL wait_event_%0d: no event within %0d cycles", kind, max);
   endtask

   task automatic set_op(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
      req_a[i*W +: W] = a;
      req_b[i*W +: W] = b;
   endtask

   task automatic hold_reset();
      reset_n = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   int g, s, d;
   int order[5];
   logic [W-1:0] rr_q[4] = '{16'h0100, 16'h0180, 16'h0200, 16'h0280};

   initial begin
      // ---- single request ----
      st_lat = 24;
      set_op(0, 16'h0300, 16'h0100);
      req = 4'b0001;
      hold_reset();
      reset_n = 1'b1;
      wait_for(0, 10, g);
      check("t1_grant_cycle", 32'(g), 32'd1);
      check("t1_grant_vec", 32'(grant), 32'h1);
      req = '0;
      wait_for(1, 10, s);
      check("t1_start_cycle", 32'(s), 32'd2);
      wait_for(2, 100, d);
      check("t1_latency", 32'(d - g), 32'd27);
      check("t1_result", 32'(result), 32'h0300);
      check("t1_ovf", 32'(ovf), 32'h0);

      // ---- round robin, all requesting continuously ----
      st_lat = 5;
      for (int i = 0; i < N; i++) set_op(i, W'(16'h0100 * (i + 2)), 16'h0200);
      req = 4'b1111;
      hold_reset();
      reset_n = 1'b1;
      for (int k = 0; k < 5; k++) begin
         wait_for(0, 20, g);
         order[k] = oh_idx(grant);
         if (k == 4) req = '0;
         wait_for(2, 50, d);
         check("rr_done_idx", 32'(oh_idx(done)), 32'(order[k]));
         if (order[k] >= 0) check("rr_result", 32'(result), 32'(rr_q[order[k]]));
      end
      check("rr_order0", 32'(order[0]), 32'd0);
      check("rr_order1", 32'(order[1]), 32'd1);
      check("rr_order2", 32'(order[2]), 32'd2);
      check("rr_order3", 32'(order[3]), 32'd3);
      check("rr_order4", 32'(order[4]), 32'd0);

      // ---- overflow passthrough ----
      set_op(2, 16'h7F00, 16'h0001);
      req = 4'b0100;
      hold_reset();
      reset_n = 1'b1;
      wait_for(0, 10, g);
      req = '0;
      wait_for(2, 50, d);
      check("ovf_done", 32'(done), 32'h4);
      check("ovf_flag", 32'(ovf), 32'h1);
      check("ovf_no_terr", 32'(timeout_err), 32'h0);

      // ---- stale finish held across the start ----
      st_stale = 1'b1;
      st_lat   = 4;
      set_op(1, 16'h0400, 16'h0200);
      req = 4'b0010;
      wait_for(0, 10, g);
      req = '0;
      wait_for(2, 50, d);
      check("stale_latency", 32'(d - g), 32'd7);
      check("stale_result", 32'(result), 32'h0200);
      check("stale_done", 32'(done), 32'h2);
      st_stale = 1'b0;

      // ---- timeout, then a normal follow-up request ----
      st_never = 1'b1;
      set_op(1, 16'h1234, 16'h0100);
      set_op(3, 16'h0100, 16'h0100);
      req = 4'b0010;
      wait_for(0, 10, g);
      req = 4'b1000;
      wait_for(1, 10, s);
      wait_for(2, 200, d);
      check("to_done", 32'(done), 32'h2);
      check("to_latency", 32'(d - s), 32'(TO + 2));
      check("to_result", 32'(result), 32'h0);
      check("to_ovf", 32'(ovf), 32'h1);
      check("to_terr", 32'(timeout_err), 32'h1);
      st_never = 1'b0;
      wait_for(0, 10, g);
      check("to_next_grant", 32'(grant), 32'h8);
      req = '0;
      wait_for(2, 50, d);
      check("to_next_done", 32'(done), 32'h8);
      check("to_next_result", 32'(result), 32'h0100);
      check("to_next_ovf", 32'(ovf), 32'h0);
      check("to_terr_sticky", 32'(timeout_err), 32'h1);

      // ---- reset in the middle of WAIT ----
      req = 4'b0010;
      wait_for(0, 10, g);
      req = '0;
      wait_for(2, 50, d);
      req = 4'b0100;
      wait_for(0, 10, g);
      req = '0;
      wait_for(1, 10, s);
      repeat (10) @(negedge clk);
      #2 reset_n = 1'b0;
      #1;
      check("rst_grant", 32'(grant), 32'h0);
      check("rst_done", 32'(done), 32'h0);
      check("rst_result", 32'(result), 32'h0);
      check("rst_ovf", 32'(ovf), 32'h0);
      check("rst_terr", 32'(timeout_err), 32'h0);
      check("rst_busy", 32'(busy), 32'h0);
      check("rst_div_a", 32'(div_a), 32'h0);
      check("rst_div_b", 32'(div_b), 32'h0);
      check("rst_div_start", 32'(div_start), 32'h0);
      req = 4'b1111;
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      wait_for(0, 10, g);
      check("rst_first_grant", 32'(grant), 32'h1);
      check("rst_first_cycle", 32'(g), 32'd1);
      req = '0;
      wait_for(2, 50, d);

      // ---- randomized traffic ----
      for (int c = 0; c < 3000; c++) begin
         @(negedge clk);
         if (div_start) begin
            st_lat   = $urandom_range(3, 30);
            st_stale = ($urandom_range(0, 3) == 0);
         end
         for (int i = 0; i < N; i++) begin
            if (req[i] && grant[i]) begin
               req[i] = ($urandom_range(0, 3) == 0);
            end else if (!req[i]) begin
               req[i] = ($urandom_range(0, 5) == 0);
            end
            if (!req[i] || grant[i] || $urandom_range(0, 7) == 0)
               set_op(i, W'($urandom), W'($urandom_range(0, 16'h0400)));
         end
      end
      req = '0;
      repeat (80) @(negedge clk);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
